clk_divider_multi: RTL and testbench
====================================

// Module: clk_divider_multi
// PURPOSE
//  Multi-channel programmable clock divider and tick generator. Successor to the fixed 12MHz->slow-clock stepdown.
//  NUM_CH independent down-counters run off clkin. Each channel has a runtime divisor and a mode:
//  TOGGLE gives a square wave; PULSE gives a 1-cycle strobe. Channels are reconfigured through a valid/ready port.
//  Feeds the state machine and display logic with slow clocks and enables.
// PARAMETERS
//  NUM_CH       2        number of divider channels (1..8)
//  CNT_W        24       counter/divisor width in bits
//  DEFAULT_DIV  1199999  reset divisor for every channel; 12MHz TOGGLE -> 5Hz
//  CH_W         3        width of cfg_ch; must satisfy 2**CH_W >= NUM_CH
// PORTS
//  clkin      in   1             system clock (12MHz on board)
//  rst_n      in   1             synchronous reset, active-low
//  en         in   1             global count enable
//  cfg_valid  in   1             config request
//  cfg_ready  out  1             config port can accept
//  cfg_ch     in   CH_W          target channel index
//  cfg_div    in   CNT_W         new divisor
//  cfg_mode   in   1             0=TOGGLE, 1=PULSE
//  cfg_err    out  1             1-cycle strobe: accepted request had cfg_ch >= NUM_CH
//  clkout     out  NUM_CH        per-channel divided clock / strobe (bit i = channel i)
//  tick       out  NUM_CH        per-channel terminal-count strobe, 1 cycle wide
// BEHAVIOUR
//  Clock and reset
//   - One clock: clkin. Reset is synchronous and active-low: sampled on the posedge of clkin while rst_n=0.
//  Reset values
//   - Every cnt[i] = DEFAULT_DIV, div[i] = DEFAULT_DIV, mode[i] = TOGGLE.
//   - clkout = 0, tick = 0, cfg_err = 0, cfg_ready = 0, FSM = INIT.
//   - A reset asserted mid-operation discards any pending config and restarts all channels from these values.
//  Channel counting (each channel i, only when en=1)
//   - When cnt[i]==0: cnt[i] <= div[i] and tick[i] <= 1. Otherwise cnt[i] <= cnt[i]-1 and tick[i] <= 0.
//   - Terminal count recurs every div+1 cycles. div=0 gives a tick every cycle.
//   - TOGGLE: clkout[i] inverts at each terminal count. Period = 2*(div+1) cycles, 50% duty.
//   - PULSE: clkout[i] = registered copy of the tick condition, identical in timing to tick[i].
//   - All outputs are registered. tick[i] and clkout[i] update on the edge where cnt[i]==0 is sampled.
//  Enable low
//   - Counters and clkout hold their values. tick is forced to 0.
//   - The config path still operates while en=0.
//  Config FSM
//   - States INIT, IDLE, APPLY. cfg_ready = (state==IDLE), registered.
//   - INIT -> IDLE unconditionally. cfg_ready rises 1 cycle after rst_n deasserts.
//   - IDLE: a handshake occurs when cfg_valid & cfg_ready. Capture ch/div/mode and go to APPLY.
//   - APPLY: lasts 1 cycle with cfg_ready=0, then returns to IDLE. Maximum throughput is 1 config per 2 cycles.
//   - Valid APPLY (ch<NUM_CH): div[ch] <= div, mode[ch] <= mode, cnt[ch] <= div, clkout[ch] <= 0, tick[ch] <= 0.
//   - This restart happens regardless of en. The first new terminal count comes div+1 enabled cycles later.
//   - Invalid ch: no channel is changed, and cfg_err pulses for 1 cycle during APPLY.
//   - APPLY coincident with terminal count on the same channel: APPLY wins and no tick is issued that cycle.
//   - Other channels are never disturbed by a config.
//   - cfg_valid with cfg_ready=0 is ignored, not queued. The requester must hold cfg_valid until it sees ready.
//  Arithmetic
//   - Unsigned, CNT_W bits. The decrement never wraps below 0 because 0 triggers the reload.
// TESTING
//  1. DEFAULT_DIV=3, NUM_CH=2, en=1 after reset -> clkout toggles every 4 cycles (period 8).
//     tick pulses every 4 cycles; cfg_ready=1 on the 1st cycle after reset release.
//  2. Config ch1 div=1 mode=PULSE -> cfg_ready low 1 cycle. ch1 tick=clkout pulse every 2 cycles starting 2 cycles after APPLY.
//     ch0 period unchanged.
//  3. en=0 for 5 cycles mid-count -> cnt/clkout frozen, tick=0. Counting resumes from the same value with no lost cycles.
//  4. Config cfg_ch=5 (NUM_CH=2) -> cfg_err high exactly 1 cycle; div/mode/clkout of all channels unchanged.
//  5. Config div=0 TOGGLE on ch0 -> clkout[0] = clkin/2, tick[0] constantly 1.
//     Config landing on a terminal-count cycle -> no tick that cycle.
//  6. rst_n=0 for 1 cycle during APPLY and mid-count -> all outputs at reset values next cycle.
//     The pending config is not applied and cfg_ready=0 then 1 after one INIT cycle.

Source files
------------

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider and tick generator.
// Each channel is a down-counter that reloads from its divisor at terminal
// count. Channels are reconfigured one at a time through a valid/ready port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | first cycle out of reset, config port not yet ready
//   ST_IDLE  | cfg_ready high, waiting for a cfg_valid handshake
//   ST_APPLY | captured request is written into its channel (1 cycle)

module clk_divider_multi #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 24,
   parameter int DEFAULT_DIV = 1199999,
   parameter int CH_W        = 3
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] clkout,
   output logic [NUM_CH-1:0] tick
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
   localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

   state_t            state_q;
   state_t            state_d;
   logic              handshake;
   logic              ch_bad;
   logic              apply_ok;
   logic [CH_W-1:0]   ch_q;
   logic [CNT_W-1:0]  div_q;
   logic              mode_q;
   logic              err_q;

   assign handshake = (state_q == ST_IDLE) && cfg_valid;
   assign ch_bad    = ({1'b0, cfg_ch} >= NUM_CH_L);
   // err_q is high exactly during APPLY of an out-of-range request
   assign apply_ok  = (state_q == ST_APPLY) && !err_q;
   assign cfg_ready = (state_q == ST_IDLE);
   assign cfg_err   = err_q;

   // Config FSM state register
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Config FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:  state_d = ST_IDLE;
         ST_IDLE:  if (cfg_valid) state_d = ST_APPLY;
         ST_APPLY: state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
   end

   // Capture the request on handshake; flag out-of-range channel for APPLY
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         ch_q   <= '0;
         div_q  <= '0;
         mode_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         err_q <= handshake && ch_bad;
         if (handshake) begin
            ch_q   <= cfg_ch;
            div_q  <= cfg_div;
            mode_q <= cfg_mode;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic             hit;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div;
      logic             mode;
      logic             clk_q;
      logic             tick_q;

      assign hit       = apply_ok && (ch_q == CH_W'(g));
      assign clkout[g] = clk_q;
      assign tick[g]   = tick_q;

      // Channel counter: config restart beats terminal count, enable gates counting
      always_ff @(posedge clkin) begin
         if (!rst_n) begin
            cnt    <= DIV_RST;
            div    <= DIV_RST;
            mode   <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else if (hit) begin
            cnt    <= div_q;
            div    <= div_q;
            mode   <= mode_q;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else if (en) begin
            if (cnt == '0) begin
               cnt    <= div;
               tick_q <= 1'b1;
               clk_q  <= mode ? 1'b1 : ~clk_q;
            end else begin
               cnt    <= cnt - 1'b1;
               tick_q <= 1'b0;
               if (mode) clk_q <= 1'b0;
            end
         end else begin
            tick_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi with DEFAULT_DIV=3 and two channels.
// Expected values are hand-derived: a channel with divisor d ticks every d+1
// enabled cycles, and a TOGGLE output flips at each tick.

module tb_clk_divider_multi;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 24;
   localparam int DEF    = 3;
   localparam int CH_W   = 3;

   logic              clkin = 1'b0;
   logic              rst_n;
   logic              en;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_mode;
   logic              cfg_err;
   logic [NUM_CH-1:0] clkout;
   logic [NUM_CH-1:0] tick;

   int total = 0;
   int bad   = 0;

   always #5 clkin = ~clkin;

   clk_divider_multi #(
      .NUM_CH(NUM_CH),
      .CNT_W(CNT_W),
      .DEFAULT_DIV(DEF),
      .CH_W(CH_W)
   ) dut (
      .clkin(clkin),
      .rst_n(rst_n),
      .en(en),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch),
      .cfg_div(cfg_div),
      .cfg_mode(cfg_mode),
      .cfg_err(cfg_err),
      .clkout(clkout),
      .tick(tick)
   );

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_mode  = 1'b0;
      step();
      step();
      chk("rst_clkout", 32'(clkout), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);

      // default divisor: both channels tick every 4 cycles, toggle period 8
      rst_n = 1'b1;
      en    = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) chk("ready_first_cycle", 32'(cfg_ready), 32'd1);
         chk("p1_tick", 32'(tick), (k % 4 == 0) ? 32'd3 : 32'd0);
         chk("p1_clkout", 32'(clkout), ((k / 4) % 2 == 1) ? 32'd3 : 32'd0);
      end

      // ch1 -> div=1 PULSE; handshake at cycle 13, APPLY at 14
      cfg_valid = 1'b1;
      cfg_ch    = 3'd1;
      cfg_div   = 24'd1;
      cfg_mode  = 1'b1;
      for (int k = 13; k <= 20; k++) begin
         step();
         if (k == 13) begin
            cfg_valid = 1'b0;
            chk("p2_ready_low", 32'(cfg_ready), 32'd0);
         end
         if (k == 14) chk("p2_ready_back", 32'(cfg_ready), 32'd1);
         chk("p2_tick0", 32'(tick[0]), (k % 4 == 0) ? 32'd1 : 32'd0);
         chk("p2_clk0", 32'(clkout[0]), ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
         if (k == 13) begin
            chk("p2_tick1", 32'(tick[1]), 32'd0);
            chk("p2_clk1", 32'(clkout[1]), 32'd1);
         end else if (k < 16) begin
            chk("p2_tick1", 32'(tick[1]), 32'd0);
            chk("p2_clk1", 32'(clkout[1]), 32'd0);
         end else begin
            chk("p2_tick1", 32'(tick[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("p2_clk1", 32'(clkout[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
         end
      end

      // enable low for 5 cycles mid-count
      step();
      chk("p3_pre_tick", 32'(tick), 32'd0);
      chk("p3_pre_clkout", 32'(clkout), 32'd1);
      en = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         step();
         chk("p3_hold_tick", 32'(tick), 32'd0);
         chk("p3_hold_clkout", 32'(clkout), 32'd1);
      end
      en = 1'b1;
      // e counts enabled cycles; counting resumes as if never paused
      for (int e = 22; e <= 24; e++) begin
         step();
         chk("p3_tick0", 32'(tick[0]), (e % 4 == 0) ? 32'd1 : 32'd0);
         chk("p3_clk0", 32'(clkout[0]), ((e / 4) % 2 == 1) ? 32'd1 : 32'd0);
         chk("p3_tick1", 32'(tick[1]), (e % 2 == 0) ? 32'd1 : 32'd0);
      end

      // out-of-range channel, then ch0 div=0 TOGGLE timed so APPLY hits ch0 terminal count
      cfg_valid = 1'b1;
      cfg_ch    = 3'd5;
      cfg_div   = 24'd7;
      cfg_mode  = 1'b0;
      for (int e = 25; e <= 27; e++) begin
         step();
         if (e == 25) begin
            cfg_valid = 1'b0;
            chk("p4_err_high", 32'(cfg_err), 32'd1);
            chk("p4_ready_low", 32'(cfg_ready), 32'd0);
         end
         if (e == 26) begin
            chk("p4_err_one_cycle", 32'(cfg_err), 32'd0);
            chk("p4_ready_back", 32'(cfg_ready), 32'd1);
            cfg_valid = 1'b1;
            cfg_ch    = 3'd0;
            cfg_div   = 24'd0;
            cfg_mode  = 1'b0;
         end
         if (e == 27) begin
            cfg_valid = 1'b0;
            chk("p5_valid_no_err", 32'(cfg_err), 32'd0);
         end
         chk("p4_tick0", 32'(tick[0]), (e % 4 == 0) ? 32'd1 : 32'd0);
         chk("p4_clk0", 32'(clkout[0]), ((e / 4) % 2 == 1) ? 32'd1 : 32'd0);
         chk("p4_tick1", 32'(tick[1]), (e % 2 == 0) ? 32'd1 : 32'd0);
         chk("p4_clk1", 32'(clkout[1]), (e % 2 == 0) ? 32'd1 : 32'd0);
      end

      step();
      chk("p5_apply_no_tick", 32'(tick[0]), 32'd0);
      chk("p5_apply_clk0", 32'(clkout[0]), 32'd0);
      chk("p5_other_tick1", 32'(tick[1]), 32'd1);
      chk("p5_other_clk1", 32'(clkout[1]), 32'd1);
      for (int j = 1; j <= 6; j++) begin
         step();
         chk("p5_div0_tick0", 32'(tick[0]), 32'd1);
         chk("p5_div0_clk0", 32'(clkout[0]), (j % 2 == 1) ? 32'd1 : 32'd0);
         chk("p5_tick1", 32'(tick[1]), ((28 + j) % 2 == 0) ? 32'd1 : 32'd0);
      end

      // reset during APPLY discards the pending ch1 config
      cfg_valid = 1'b1;
      cfg_ch    = 3'd1;
      cfg_div   = 24'd5;
      cfg_mode  = 1'b0;
      step();
      chk("p6_ready_low", 32'(cfg_ready), 32'd0);
      cfg_valid = 1'b0;
      rst_n     = 1'b0;
      step();
      chk("p6_rst_clkout", 32'(clkout), 32'd0);
      chk("p6_rst_tick", 32'(tick), 32'd0);
      chk("p6_rst_ready", 32'(cfg_ready), 32'd0);
      chk("p6_rst_err", 32'(cfg_err), 32'd0);
      rst_n = 1'b1;
      for (int r = 1; r <= 8; r++) begin
         step();
         if (r == 1) chk("p6_ready_after_init", 32'(cfg_ready), 32'd1);
         chk("p6_tick", 32'(tick), (r % 4 == 0) ? 32'd3 : 32'd0);
         chk("p6_clkout", 32'(clkout), ((r / 4) % 2 == 1) ? 32'd3 : 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
